// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
//   Multiplexed 7-segment scan controller. Walks N_DIGITS digit slots of
//   DWELL clk_slow cycles each. Digits 0..N_DIGITS/2-1 drive seg_out1 and the
//   rest drive seg_out2. The brightness input is a PWM setting: it gives the
//   number of on-cycles per slot minus 1, and values above DWELL-1 saturate.
//   blank_mask darkens single digits. The display buffer is double-buffered
//   and changes only at a frame boundary, so a frame is never shown torn.
//
// Ports
//   clk_slow    in   scan clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   frame_in    in   [8*N_DIGITS] segment patterns, digit i = frame_in[8*i+:8]
//   frame_load  in   request to copy frame_in into the display buffer
//   frame_ack   out  one-cycle pulse: the buffer was updated at this edge
//   blank_mask  in   [N_DIGITS] 1 = digit dark during its slot
//   blink_mask  in   [N_DIGITS] (SEG_BLINK_EN only) digits that blink
//   brightness  in   [BRIGHT_W] on-cycles per slot minus 1, saturating
//   frame_start out  one-cycle pulse while digit 0 / dwell 0 is output
//   seg_en      out  [N_DIGITS] one-hot digit enable, active high
//   seg_out1    out  [8] segment bus, lower digit group
//   seg_out2    out  [8] segment bus, upper digit group
//
// Configuration
//   SEG_BLINK_EN: adds blink_mask and parameter BLINK_FRAMES. The blink phase
//   toggles every BLINK_FRAMES frames and is on after reset. In the off phase,
//   digits that are set in blink_mask are dark.
//
// Load handshake (frame_load / frame_ack)
//   frame_load is a level request. A request seen at any edge is remembered
//   in pending. At the frame-boundary edge (last digit, last dwell cycle) a
//   pending request, or a frame_load high at that edge, copies frame_in into
//   the buffer. That edge clears pending and raises frame_ack for one cycle.
//   The source keeps frame_in stable from frame_load until frame_ack.
//   Requests that arrive while one is pending merge into it. Reset drops a
//   pending request and does not send an ack for it.
module seg_scan_ctrl #(
  parameter int N_DIGITS = 8,
  parameter int DWELL    = 4,
  parameter int BRIGHT_W = 8
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic                  clk_slow,
  input  logic                  rst_n,
  input  logic [8*N_DIGITS-1:0] frame_in,
  input  logic                  frame_load,
  output logic                  frame_ack,
  input  logic [N_DIGITS-1:0]   blank_mask,
`ifdef SEG_BLINK_EN
  input  logic [N_DIGITS-1:0]   blink_mask,
`endif
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic                  frame_start,
  output logic [N_DIGITS-1:0]   seg_en,
  output logic [7:0]            seg_out1,
  output logic [7:0]            seg_out2
);

  localparam int IW   = $clog2(N_DIGITS);
  localparam int DW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int HALF = N_DIGITS / 2;

  logic [IW-1:0]                idx;
  logic [DW-1:0]                dcnt;
  logic                         pending;
  logic [N_DIGITS-1:0][7:0]     frame_buf;
  logic [BRIGHT_W-1:0]          bright_q;

  logic                         last_dwell;
  logic                         at_boundary;
  logic                         load_now;
  logic [BRIGHT_W-1:0]          eff_bright;
  logic                         dark;
  logic                         lit;
  logic                         in_lower;
  logic [7:0]                   cur_seg;

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] fcnt;
  logic          blink_on;

  // The blink phase changes only at the frame boundary, so a whole frame
  // uses the same phase.
  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      fcnt     <= '0;
      blink_on <= 1'b1;
    end else if (at_boundary) begin
      if (fcnt == FW'(BLINK_FRAMES - 1)) begin
        fcnt     <= '0;
        blink_on <= ~blink_on;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    last_dwell  = (dcnt == DW'(DWELL - 1));
    at_boundary = last_dwell && (idx == IW'(N_DIGITS - 1));
    load_now    = at_boundary && (pending || frame_load);
    // At dwell 0 the live brightness value is used. For the rest of the slot
    // the value captured at that edge is used.
    eff_bright  = (dcnt == '0) ? brightness : bright_q;
`ifdef SEG_BLINK_EN
    dark        = blank_mask[idx] || (!blink_on && blink_mask[idx]);
`else
    dark        = blank_mask[idx];
`endif
    // dcnt never exceeds DWELL-1. So comparing it directly with the
    // brightness value already saturates at a fully lit slot.
    lit         = (32'(dcnt) <= 32'(eff_bright)) && !dark;
    in_lower    = (idx < IW'(HALF));
    cur_seg     = frame_buf[idx];
  end

  // Scan counters, load handshake and display buffer.
  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      dcnt      <= '0;
      pending   <= 1'b0;
      frame_buf <= '0;
      bright_q  <= '0;
    end else begin
      if (dcnt == '0) bright_q <= brightness;
      if (last_dwell) begin
        dcnt <= '0;
        idx  <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
      if (load_now) begin
        frame_buf <= frame_in;
        pending   <= 1'b0;
      end else if (frame_load) begin
        pending   <= 1'b1;
      end
    end
  end

  // Registered outputs. They show the counter state from one cycle earlier.
  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      seg_en      <= '0;
      seg_out1    <= '0;
      seg_out2    <= '0;
      frame_ack   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      seg_en      <= lit ? (N_DIGITS'(1) << idx) : '0;
      seg_out1    <= (lit && in_lower)  ? cur_seg : 8'h00;
      seg_out2    <= (lit && !in_lower) ? cur_seg : 8'h00;
      frame_ack   <= load_now;
      frame_start <= (idx == '0) && (dcnt == '0);
    end
  end

endmodule
